// File: rtl/grayscale.sv
// RGB-to-grayscale front end for the edge-detection pipeline: two registered stages with
// FIFO back-pressure and raster tracking. Define GRAYSCALE_LUMA_EN for BT.601 luma; otherwise exact (R+G+B)/3.
module grayscale #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 720,
  parameter int IMAGE_HEIGHT = 540
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_empty,
  input  logic [3*DATA_WIDTH-1:0] rgb_in,
  output logic                    read_fifo,
  input  logic                    output_full,
  output logic                    write_fifo,
  output logic [DATA_WIDTH-1:0]   gray_out,
  output logic                    frame_done
);

  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [DATA_WIDTH-1:0] GRAY_MAX = '1;

  logic [DATA_WIDTH-1:0] chanR, chanG, chanB;
  logic                  en1, en2;
  logic                  v1_q, v2_q;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  colLast, rowLast;

  assign chanR = rgb_in[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign chanG = rgb_in[2*DATA_WIDTH-1:DATA_WIDTH];
  assign chanB = rgb_in[DATA_WIDTH-1:0];

  // A stage may advance when it is empty or when the stage after it is draining.
  assign en2        = !v2_q || !output_full;
  assign en1        = !v1_q || en2;
  assign read_fifo  = !rst && !input_empty && en1;
  assign write_fifo = !rst && v2_q && !output_full;
  assign gray_out   = gray_q;

`ifdef GRAYSCALE_LUMA_EN
  localparam int SUMW = 2*DATA_WIDTH + 2;

  logic [SUMW-1:0] prodR_q, prodG_q, prodB_q;
  logic [SUMW-1:0] prodR_d, prodG_d, prodB_d;
  logic [SUMW-1:0] lumaSum, lumaScaled;

  always_comb begin
    prodR_d    = SUMW'(chanR) * SUMW'(77);
    prodG_d    = SUMW'(chanG) * SUMW'(150);
    prodB_d    = SUMW'(chanB) * SUMW'(29);
    lumaSum    = prodR_q + prodG_q + prodB_q + SUMW'(128);
    lumaScaled = lumaSum >> 8;
    gray_d     = (lumaScaled > SUMW'(GRAY_MAX)) ? GRAY_MAX : lumaScaled[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prodR_q <= '0;
      prodG_q <= '0;
      prodB_q <= '0;
    end else if (read_fifo) begin
      prodR_q <= prodR_d;
      prodG_q <= prodG_d;
      prodB_q <= prodB_d;
    end
  end
`else
  localparam int AVGW = DATA_WIDTH + 2;

  logic [AVGW-1:0] sum_q, sum_d, avgQuot;

  // Division by a constant keeps the average exact rather than a multiply-shift approximation.
  always_comb begin
    sum_d   = AVGW'(chanR) + AVGW'(chanG) + AVGW'(chanB);
    avgQuot = sum_q / AVGW'(3);
    gray_d  = (avgQuot > AVGW'(GRAY_MAX)) ? GRAY_MAX : avgQuot[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (read_fifo) begin
      sum_q <= sum_d;
    end
  end
`endif

  assign colLast    = (col_q == CW'(IMAGE_WIDTH - 1));
  assign rowLast    = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign frame_done = write_fifo && colLast && rowLast;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (write_fifo) begin
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      gray_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      if (en1) v1_q <= read_fifo;
      if (en2) v2_q <= v1_q;
      if (en2 && v1_q) gray_q <= gray_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: tb/tb_grayscale.sv
// Directed bench for grayscale with a 4x3 frame; expected values are hand-computed
// for both the average build and the GRAYSCALE_LUMA_EN build.
module tb_grayscale;

  logic        clk;
  logic        rst;
  logic        input_empty;
  logic [23:0] rgb_in;
  logic        read_fifo;
  logic        output_full;
  logic        write_fifo;
  logic [7:0]  gray_out;
  logic        frame_done;

  int compared;
  int mismatched;

  int          cycleNo;
  logic [23:0] inQ[$];
  int          outQ[$];
  int          wrCycle[$];
  int          rdCycle[$];
  int          doneAt[$];
  bit          rdTrace[$];
  bit          wrTrace[$];
  int          grayTrace[$];

  grayscale #(
    .DATA_WIDTH  (8),
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_empty(input_empty),
    .rgb_in     (rgb_in),
    .read_fifo  (read_fifo),
    .output_full(output_full),
    .write_fifo (write_fifo),
    .gray_out   (gray_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic clearLogs();
    cycleNo = 0;
    inQ.delete();
    outQ.delete();
    wrCycle.delete();
    rdCycle.delete();
    doneAt.delete();
    rdTrace.delete();
    wrTrace.delete();
    grayTrace.delete();
  endtask

  task automatic doReset();
    rst         = 1'b1;
    input_empty = 1'b1;
    output_full = 1'b0;
    rgb_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clearLogs();
  endtask

  // Drives one cycle from the input queue; called 1 time unit after a rising edge.
  task automatic runCycle(input bit gateEmpty, input bit fullVal);
    bit rd, wr, fd;
    int g;
    input_empty = gateEmpty || (inQ.size() == 0);
    rgb_in      = (inQ.size() != 0) ? inQ[0] : 24'd0;
    output_full = fullVal;
    @(negedge clk);
    rd = read_fifo;
    wr = write_fifo;
    fd = frame_done;
    g  = int'(gray_out);
    rdTrace.push_back(rd);
    wrTrace.push_back(wr);
    grayTrace.push_back(g);
    if (rd) rdCycle.push_back(cycleNo);
    if (wr) begin
      outQ.push_back(g);
      wrCycle.push_back(cycleNo);
      if (fd) doneAt.push_back(outQ.size());
    end else if (fd) begin
      doneAt.push_back(-1);
    end
    @(posedge clk);
    #1;
    if (rd) void'(inQ.pop_front());
    cycleNo++;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    input_empty = 1'b0;
    output_full = 1'b0;
    rgb_in      = pix(255, 255, 255);
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (read_fifo !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_read_fifo: got %b, expected 0", read_fifo);
    end
    compared++;
    if (write_fifo !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_write_fifo: got %b, expected 0", write_fifo);
    end
    compared++;
    if (gray_out !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_gray_out: got %0d, expected 0", gray_out);
    end
    compared++;
    if (frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_frame_done: got %b, expected 0", frame_done);
    end
  endtask

  task automatic test_color_points();
    int expGray[5];
`ifdef GRAYSCALE_LUMA_EN
    expGray = '{77, 149, 29, 255, 0};
`else
    expGray = '{85, 85, 85, 255, 0};
`endif
    doReset();
    inQ.push_back(pix(255, 0, 0));
    inQ.push_back(pix(0, 255, 0));
    inQ.push_back(pix(0, 0, 255));
    inQ.push_back(pix(255, 255, 255));
    inQ.push_back(pix(0, 0, 0));
    repeat (10) runCycle(1'b0, 1'b0);
    compared++;
    if (outQ.size() != 5) begin
      mismatched++;
      $display("FAIL color_count: got %0d writes, expected 5", outQ.size());
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (i >= outQ.size() || outQ[i] != expGray[i]) begin
        mismatched++;
        $display("FAIL color_value[%0d]: got %0d, expected %0d", i,
                 (i < outQ.size()) ? outQ[i] : -1, expGray[i]);
      end
    end
    compared++;
    if (wrCycle.size() < 5 || rdCycle.size() < 1 || wrCycle[0] - rdCycle[0] != 2) begin
      mismatched++;
      $display("FAIL color_latency: got %0d cycles, expected 2",
               (wrCycle.size() > 0 && rdCycle.size() > 0) ? wrCycle[0] - rdCycle[0] : -1);
    end else begin
      compared++;
      if (wrCycle[4] - wrCycle[0] != 4) begin
        mismatched++;
        $display("FAIL color_back_to_back: got span %0d, expected 4", wrCycle[4] - wrCycle[0]);
      end
    end
  endtask

  task automatic test_back_pressure();
    doReset();
    for (int i = 0; i < 10; i++) inQ.push_back(pix(i, i, i));
    for (int c = 0; c < 25; c++) runCycle(1'b0, (c >= 4) && (c <= 9));
    compared++;
    if (outQ.size() != 10 || rdCycle.size() != 10) begin
      mismatched++;
      $display("FAIL bp_count: got %0d writes / %0d pops, expected 10 / 10", outQ.size(), rdCycle.size());
    end
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (i >= outQ.size() || outQ[i] != i) begin
        mismatched++;
        $display("FAIL bp_order[%0d]: got %0d, expected %0d", i, (i < outQ.size()) ? outQ[i] : -1, i);
      end
    end
    compared++;
    if (rdTrace[3] !== 1'b1 || rdTrace[5] !== 1'b0 || rdTrace[9] !== 1'b0 || rdTrace[10] !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_read_stall: got rd[3,5,9,10]=%b%b%b%b, expected 1001",
               rdTrace[3], rdTrace[5], rdTrace[9], rdTrace[10]);
    end
    for (int c = 4; c <= 9; c++) begin
      compared++;
      if (wrTrace[c] !== 1'b0 || grayTrace[c] != 2) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: got write=%b gray=%0d, expected write=0 gray=2", c, wrTrace[c], grayTrace[c]);
      end
    end
  endtask

  task automatic test_bubbles();
    int oddWrites;
    doReset();
    for (int k = 0; k < 8; k++) inQ.push_back(pix(10*k + 3, 10*k + 3, 10*k + 3));
    for (int c = 0; c < 24; c++) runCycle(c % 2 == 1, 1'b0);
    compared++;
    if (outQ.size() != 8) begin
      mismatched++;
      $display("FAIL bubble_count: got %0d writes, expected 8", outQ.size());
    end
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (k >= outQ.size() || outQ[k] != 10*k + 3) begin
        mismatched++;
        $display("FAIL bubble_value[%0d]: got %0d, expected %0d", k, (k < outQ.size()) ? outQ[k] : -1, 10*k + 3);
      end
    end
    oddWrites = 0;
    for (int c = 1; c < 24; c += 2) if (wrTrace[c]) oddWrites++;
    compared++;
    if (oddWrites != 0) begin
      mismatched++;
      $display("FAIL bubble_odd_writes: got %0d, expected 0", oddWrites);
    end
  endtask

  task automatic test_frame();
    doReset();
    for (int k = 0; k < 24; k++) inQ.push_back(pix(k, k, k));
    repeat (30) runCycle(1'b0, 1'b0);
    compared++;
    if (outQ.size() != 24) begin
      mismatched++;
      $display("FAIL frame_count: got %0d writes, expected 24", outQ.size());
    end
    compared++;
    if (doneAt.size() != 2 || doneAt[0] != 12 || doneAt[1] != 24) begin
      mismatched++;
      $display("FAIL frame_done_pos: got %0d pulses (first at %0d), expected 2 at 12 and 24",
               doneAt.size(), (doneAt.size() > 0) ? doneAt[0] : -1);
    end
    compared++;
    if (wrCycle.size() != 24 || wrCycle[23] - wrCycle[0] != 23) begin
      mismatched++;
      $display("FAIL frame_throughput: got span %0d, expected 23",
               (wrCycle.size() == 24) ? wrCycle[23] - wrCycle[0] : -1);
    end
    compared++;
    if (outQ.size() != 24 || outQ[11] != 11 || outQ[12] != 12) begin
      mismatched++;
      $display("FAIL frame_values: got %0d/%0d, expected 11/12",
               (outQ.size() > 12) ? outQ[11] : -1, (outQ.size() > 12) ? outQ[12] : -1);
    end
  endtask

  task automatic test_reset_midop();
    doReset();
    for (int k = 0; k < 6; k++) inQ.push_back(pix(100, 100, 100));
    runCycle(1'b0, 1'b0);
    runCycle(1'b0, 1'b0);
    input_empty = 1'b0;
    rgb_in      = inQ[0];
    output_full = 1'b1;
    #1;
    compared++;
    if (gray_out !== 8'd100) begin
      mismatched++;
      $display("FAIL midop_pre_gray: got %0d, expected 100", gray_out);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (read_fifo !== 1'b0 || write_fifo !== 1'b0 || frame_done !== 1'b0 || gray_out !== 8'd0) begin
      mismatched++;
      $display("FAIL midop_async_clear: got rd=%b wr=%b fd=%b gray=%0d, expected 0 0 0 0",
               read_fifo, write_fifo, frame_done, gray_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearLogs();
    for (int k = 0; k < 12; k++) inQ.push_back(pix(k + 40, k + 40, k + 40));
    repeat (20) runCycle(1'b0, 1'b0);
    compared++;
    if (outQ.size() != 12 || outQ[0] != 40) begin
      mismatched++;
      $display("FAIL midop_restart: got %0d writes first=%0d, expected 12 first=40",
               outQ.size(), (outQ.size() > 0) ? outQ[0] : -1);
    end
    compared++;
    if (doneAt.size() != 1 || doneAt[0] != 12) begin
      mismatched++;
      $display("FAIL midop_frame_done: got %0d pulses (first at %0d), expected 1 at 12",
               doneAt.size(), (doneAt.size() > 0) ? doneAt[0] : -1);
    end
  endtask

  task automatic test_precision();
    int expGray[6];
`ifdef GRAYSCALE_LUMA_EN
    expGray = '{1, 2, 255, 255, 1, 0};
`else
    expGray = '{0, 2, 254, 254, 1, 0};
`endif
    doReset();
    inQ.push_back(pix(1, 1, 0));
    inQ.push_back(pix(2, 2, 2));
    inQ.push_back(pix(254, 255, 255));
    inQ.push_back(pix(255, 255, 254));
    inQ.push_back(pix(3, 0, 0));
    inQ.push_back(pix(0, 0, 2));
    repeat (12) runCycle(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= outQ.size() || outQ[i] != expGray[i]) begin
        mismatched++;
        $display("FAIL precision[%0d]: got %0d, expected %0d", i,
                 (i < outQ.size()) ? outQ[i] : -1, expGray[i]);
      end
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    input_empty = 1'b1;
    output_full = 1'b0;
    rgb_in      = '0;
    clearLogs();
    test_reset();
    test_color_points();
    test_back_pressure();
    test_bubbles();
    test_frame();
    test_reset_midop();
    test_precision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/grayscale.md
Name: grayscale

Overview:
- Pixel-rate front end of the edge-detection pipeline, sitting directly upstream of the sobel stage.
- Pops packed RGB pixels from the input FIFO, converts each to an 8-bit grayscale value, and pushes it into the FIFO that feeds sobel.
- Two-stage pipeline with full back-pressure; tracks raster position and flags end of frame.

Parameters:
DATA_WIDTH, 8, bits per colour channel and per gray output
IMAGE_WIDTH, 720, pixels per row
IMAGE_HEIGHT, 540, rows per frame

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
input_empty  in  1  input FIFO empty (first-word-fall-through)
rgb_in  in  3*DATA_WIDTH  {R[23:16], G[15:8], B[7:0]}; valid whenever !input_empty
read_fifo  out  1  pop input FIFO this cycle; rgb_in captured same edge
output_full  in  1  output FIFO full
write_fifo  out  1  push gray_out into output FIFO this cycle
gray_out  out  DATA_WIDTH  grayscale pixel
frame_done  out  1  one-cycle pulse with the write of the last pixel of a frame

Behaviour:
- Reset values: read_fifo=0, write_fifo=0, gray_out=0, frame_done=0; v1=v2=0; col=0, row=0.
- Stage 1 (S1): registers the three weighted channel products plus valid bit v1.
- Stage 2 (S2): registers the rounded/saturated sum (drives gray_out) plus valid bit v2.
- Handshake, all combinational from registered state and FIFO flags:
  - en2 = !v2 | !output_full
  - en1 = !v1 | en2
  - read_fifo = !input_empty & en1
  - write_fifo = v2 & !output_full
- Latency: pixel popped at edge N appears on gray_out with write_fifo high in cycle N+2 when output not full.
- Throughput: 1 pixel/clk sustained.
- Stalls:
  - output_full holds S2; S1 holds if also valid.
  - No pixel is dropped or duplicated.
  - gray_out remains stable while v2 & output_full.
- Bubbles: input_empty inserts bubbles (v1=0). A bubble never produces write_fifo.
- Simultaneous events: S2 write and S1->S2 transfer on the same edge are permitted. Pop and S1 load on the same edge as S1->S2 transfer are permitted.
- Arithmetic: unsigned.
  - Luma mode: gray = (77*R + 150*G + 29*B + 128) >> 8.
  - Sum width is 2*DATA_WIDTH+2 bits. Result saturates at 2^DATA_WIDTH-1; no wrap.
- Position counters: col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) advance only on write_fifo.
  - col wraps to 0 and row increments at col==IMAGE_WIDTH-1.
  - At col==IMAGE_WIDTH-1 & row==IMAGE_HEIGHT-1, both wrap to 0 and frame_done=1 in that same cycle (combinational with write_fifo).
- No frame-level state machine: frames stream back-to-back with no gap cycles required.
- Reset mid-frame: pipeline contents discarded, counters cleared, outputs return to reset values immediately (asynchronous). The next popped pixel is treated as (row 0, col 0).

Optional Feature:
- Macro GRAYSCALE_LUMA_EN.
- Defined: BT.601 weighted luma as above.
- Undefined: gray = floor((R+G+B)/3), computed exactly (no approximation error), with the same two-stage latency, handshake, and counters. S1 then registers R+G+B (DATA_WIDTH+2 bits).

Test Plan:
- Luma colour points: push (255,0,0), (0,255,0), (0,0,255), (255,255,255), (0,0,0) with output never full -> gray_out 77, 149, 29, 255, 0 on consecutive cycles, first write exactly 2 clk after first read_fifo. Average mode gives 85, 85, 85, 255, 0.
- Back-pressure: stream 10 pixels (R=G=B=i, i=0..9); hold output_full high cycles 4-9 -> read_fifo deasserts once S1 and S2 are full, gray_out holds stable, and the output sequence is 0..9 exactly once each, in order.
- Bubbles: input_empty toggles every other cycle over 8 pixels -> write_fifo only for valid pixels, 8 writes total, no repeats.
- Frame boundary with IMAGE_WIDTH=4, IMAGE_HEIGHT=3: stream 24 pixels -> frame_done pulses exactly on write #12 and #24, 1 cycle each; col/row back to 0 after each.
- Reset mid-operation: assert rst asynchronously while v1=v2=1 and output_full=1 -> write_fifo, read_fifo, frame_done drop to 0 without a clock edge. After release, a 12-pixel frame (4x3) yields frame_done on the 12th write.
- Saturation/average precision (macro undefined): (1,1,0) -> 0; (2,2,2) -> 2; (254,255,255) -> 254.
